// File: rtl/ysyx_22040365_seq_pkg.sv
// Shared constants for the instruction sequencer: state encoding, the ebreak
// opcode and the halt-cause codes reported on err.
package ysyx_22040365_seq_pkg;

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  localparam logic [1:0] ERR_EBREAK  = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  function automatic logic is_ebreak(input logic [31:0] word);
    return word == EBREAK_INST;
  endfunction

endpackage

// File: rtl/ysyx_22040365_seq_cnt64.sv
// 64-bit event counter with synchronous clear and enable; wraps modulo 2^64.
module ysyx_22040365_cnt64 (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  output logic [63:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= 64'd0;
    end else if (en) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_22040365_seq.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, write-back,
// with sticky halt on ebreak, illegal instruction or fetch timeout.
//
// state  | meaning
// RESET  | one settling cycle after rst, then fetch
// FETCH  | imem_req high at pc, wait for imem_valid (bounded)
// DECODE | ren_rs1 pulse; ebreak / illegal check
// EXEC   | ex_en pulse
// WB     | wen_rd pulse, pc += 4, retired += 1
// HALT   | stopped until rst; err holds the cause
module ysyx_22040365_seq
  import ysyx_22040365_seq_pkg::*;
#(
  parameter logic [63:0] RESET_PC      = 64'h8000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  input  logic        inst_legal,
  output logic        ren_rs1,
  output logic        ex_en,
  output logic        wen_rd,
  output logic [63:0] pc,
  output logic        halt,
  output logic [1:0]  err,
  output logic [63:0] retired
);

  localparam int WCW = $clog2(FETCH_TIMEOUT + 1);
  // Last waiting cycle: a missing valid here means FETCH_TIMEOUT empty cycles.
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(FETCH_TIMEOUT - 1);

  logic [2:0]     state;
  logic [WCW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RESET;
      pc       <= RESET_PC;
      inst     <= 32'd0;
      err      <= ERR_EBREAK;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_RESET: state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_valid) begin
            inst     <= imem_rdata;
            wait_cnt <= '0;
            state    <= ST_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            err      <= ERR_TIMEOUT;
            state    <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        ST_DECODE: begin
          if (is_ebreak(inst)) begin
            err   <= ERR_EBREAK;
            state <= ST_HALT;
          end else if (!inst_legal) begin
            err   <= ERR_ILLEGAL;
            state <= ST_HALT;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: state <= ST_WB;
        ST_WB: begin
          pc    <= pc + 64'd4;
          state <= ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_RESET;
      endcase
    end
  end

  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;
  assign ren_rs1   = (state == ST_DECODE);
  assign ex_en     = (state == ST_EXEC);
  assign wen_rd    = (state == ST_WB);
  assign halt      = (state == ST_HALT);

  ysyx_22040365_cnt64 u_retired (
    .clk   (clk),
    .clr   (rst),
    .en    (wen_rd),
    .count (retired)
  );

endmodule

// File: tb/tb_ysyx_22040365_seq.sv
// Bench for the sequencer: an instruction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ysyx_22040365_seq;

  localparam logic [63:0] PC0     = 64'h8000_0000;
  localparam logic [63:0] PCW0    = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam int          TMO     = 16;
  localparam logic [31:0] EBREAK  = 32'h0010_0073;
  localparam logic [31:0] ADDI    = 32'h0010_0093;
  localparam logic [31:0] ADDI2   = 32'h0020_8113;
  localparam logic [31:0] JUNK    = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        inst_legal;

  logic        imem_req, ren_rs1, ex_en, wen_rd, halt;
  logic [63:0] imem_addr, pc, retired;
  logic [31:0] inst;
  logic [1:0]  err;

  logic        imem_req_w, ren_w, ex_w, wen_w, halt_w;
  logic [63:0] imem_addr_w, pc_w, retired_w;
  logic [31:0] inst_w;
  logic [1:0]  err_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_22040365_seq #(.RESET_PC(PC0), .FETCH_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .inst(inst),
    .inst_legal(inst_legal), .ren_rs1(ren_rs1), .ex_en(ex_en), .wen_rd(wen_rd),
    .pc(pc), .halt(halt), .err(err), .retired(retired)
  );

  ysyx_22040365_seq #(.RESET_PC(PCW0), .FETCH_TIMEOUT(TMO)) dut_w (
    .clk(clk), .rst(rst), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .inst(inst_w),
    .inst_legal(inst_legal), .ren_rs1(ren_w), .ex_en(ex_w), .wen_rd(wen_w),
    .pc(pc_w), .halt(halt_w), .err(err_w), .retired(retired_w)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks where the current instruction is by its age since
  // acceptance (1 decode, 2 execute, 3 write-back) rather than a state code.
  bit          m_live = 0;
  bit          m_boot = 0, m_fetch = 0, m_halt = 0;
  int          m_age = 0, m_wait = 0;
  logic [1:0]  m_err = 2'd0;
  logic [63:0] m_pc = PC0, m_pcw = PCW0, m_ret = 64'd0;
  logic [31:0] m_inst = 32'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1; m_boot = 1; m_fetch = 0; m_halt = 0; m_age = 0; m_wait = 0;
      m_err = 2'd0; m_pc = PC0; m_pcw = PCW0; m_ret = 64'd0; m_inst = 32'd0;
    end else if (m_boot) begin
      m_boot = 0; m_fetch = 1; m_wait = 0;
    end else if (!m_halt) begin
      if (m_fetch) begin
        if (imem_valid) begin
          m_inst = imem_rdata; m_fetch = 0; m_age = 1;
        end else begin
          m_wait++;
          if (m_wait == TMO) begin m_halt = 1; m_err = 2'd2; m_fetch = 0; end
        end
      end else if (m_age == 1) begin
        if (m_inst == EBREAK) begin m_halt = 1; m_err = 2'd0; m_age = 0; end
        else if (!inst_legal) begin m_halt = 1; m_err = 2'd1; m_age = 0; end
        else m_age = 2;
      end else if (m_age == 2) begin
        m_age = 3;
      end else if (m_age == 3) begin
        m_pc += 64'd4; m_pcw += 64'd4; m_ret += 64'd1;
        m_age = 0; m_fetch = 1; m_wait = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("req",     64'(imem_req), 64'(m_fetch && !m_boot && !m_halt));
      if (m_fetch && !m_boot && !m_halt) begin
        chk("addr",   imem_addr,   m_pc);
        chk("addr_w", imem_addr_w, m_pcw);
      end
      chk("ren",     64'(ren_rs1), 64'(m_age == 1));
      chk("ex",      64'(ex_en),   64'(m_age == 2));
      chk("wen",     64'(wen_rd),  64'(m_age == 3));
      chk("inst",    64'(inst),    64'(m_inst));
      chk("pc",      pc,           m_pc);
      chk("halt",    64'(halt),    64'(m_halt));
      chk("err",     64'(err),     64'(m_err));
      chk("retired", retired,      m_ret);
      chk("pc_w",    pc_w,         m_pcw);
      chk("strb_w",  64'({imem_req_w, ren_w, ex_w, wen_w, halt_w}),
                     64'({imem_req, ren_rs1, ex_en, wen_rd, halt}));
      chk("state_w", {inst_w, 30'd0, err_w}, {inst, 30'd0, err});
      chk("ret_w",   retired_w,    retired);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_valid = 1'b1; imem_rdata = JUNK; inst_legal = 1'b1;
    tick(); tick();
    chk("rst_inst", 64'(inst), 64'd0);
    rst = 1'b0; imem_valid = 1'b0;
  endtask

  initial begin
    int wen_cnt, req_cnt, ex_cnt, n;
    rst = 1'b1; imem_valid = 1'b0; imem_rdata = 32'd0; inst_legal = 1'b1;
    tick(); tick();
    chk("rst_pc", pc, PC0);
    chk("rst_ret", retired, 64'd0);
    chk("rst_halt_err", 64'({halt, err}), 64'd0);
    chk("rst_strobes", 64'({imem_req, ren_rs1, ex_en, wen_rd}), 64'd0);

    // valid held high throughout: only FETCH cycles may consume it
    rst = 1'b0; imem_valid = 1'b1; imem_rdata = ADDI;
    wen_cnt = 0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (wen_rd) wen_cnt++;
      if (i == 1) begin chk("s1_addr0", imem_addr, 64'h8000_0000); chk("s1_req0", 64'(imem_req), 64'd1); end
      if (i == 5) begin chk("s1_addr1", imem_addr, 64'h8000_0004); chk("wrap_pc", pc_w, 64'd0); end
      if (i == 9) chk("s1_addr2", imem_addr, 64'h8000_0008);
      if (i == 12) chk("s1_ret2", retired, 64'd2);
    end
    chk("s1_ret3", retired, 64'd3);
    chk("s1_wen_cnt", 64'(wen_cnt), 64'd3);

    // valid arrives after 5 empty fetch cycles
    imem_valid = 1'b0; req_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (imem_req) req_cnt++;
      chk("s2_addr", imem_addr, 64'h8000_000C);
      chk("s2_quiet", 64'({ren_rs1, ex_en, wen_rd}), 64'd0);
      if (k == 5) begin imem_valid = 1'b1; imem_rdata = ADDI2; end
      tick();
    end
    chk("s2_req_cnt", 64'(req_cnt), 64'd6);
    chk("s2_ren", 64'({imem_req, ren_rs1}), 64'b01);
    imem_valid = 1'b0;
    tick(); tick(); tick();
    chk("s2_pc", pc, 64'h8000_0010);
    chk("s2_ret", retired, 64'd4);

    // fetch timeout
    req_cnt = 0; n = 0;
    while (!halt && n < 40) begin
      if (imem_req) req_cnt++;
      tick(); n++;
    end
    chk("s3_halt", 64'(halt), 64'd1);
    chk("s3_err", 64'(err), 64'd2);
    chk("s3_pc", pc, 64'h8000_0010);
    chk("s3_ret", retired, 64'd4);
    chk("s3_req_cnt", 64'(req_cnt), 64'd16);
    imem_valid = 1'b1; imem_rdata = EBREAK;
    tick(); tick(); tick();
    chk("s3_hold", {inst, 28'd0, 2'(err), 1'b0, halt}, {ADDI2, 28'd0, 2'd2, 1'b0, 1'b1});

    // ebreak wins over inst_legal = 0
    do_reset();
    imem_valid = 1'b1; imem_rdata = EBREAK; inst_legal = 1'b0;
    n = 0; ex_cnt = 0; wen_cnt = 0;
    while (!halt && n < 10) begin
      if (ex_en) ex_cnt++;
      if (wen_rd) wen_cnt++;
      tick(); n++;
    end
    chk("s4_halt", 64'(halt), 64'd1);
    chk("s4_err", 64'(err), 64'd0);
    chk("s4_no_ex_wb", 64'(ex_cnt + wen_cnt), 64'd0);
    chk("s4_pc_ret", pc + retired, 64'h8000_0000);

    // illegal instruction
    do_reset();
    imem_valid = 1'b1; imem_rdata = 32'hFFFF_FFFF; inst_legal = 1'b0;
    n = 0;
    while (!halt && n < 10) begin tick(); n++; end
    chk("s5_halt", 64'(halt), 64'd1);
    chk("s5_err", 64'(err), 64'd1);
    chk("s5_ret", retired, 64'd0);

    // valid on the last allowed fetch cycle is accepted
    do_reset();
    imem_valid = 1'b0; inst_legal = 1'b1;
    tick();
    for (int j = 0; j < TMO - 1; j++) tick();
    chk("s6_not_halted", 64'({halt, imem_req}), 64'b01);
    imem_valid = 1'b1; imem_rdata = ADDI;
    tick();
    chk("s6_accepted", 64'({halt, ren_rs1}), 64'b01);
    imem_valid = 1'b0;
    tick(); tick(); tick();
    chk("s6_ret", retired, 64'd1);
    chk("s6_pc", pc, 64'h8000_0004);

    // reset during EXEC, then reset coincident with a fetch response
    imem_valid = 1'b1; imem_rdata = ADDI2;
    tick(); imem_valid = 1'b0;
    tick();
    chk("s7_in_exec", 64'(ex_en), 64'd1);
    rst = 1'b1;
    tick();
    chk("s7_pc", pc, 64'h8000_0000);
    chk("s7_ret", retired, 64'd0);
    chk("s7_strobes", 64'({imem_req, ren_rs1, ex_en, wen_rd, halt}), 64'd0);
    rst = 1'b0;
    tick();
    chk("s7_fetch", 64'(imem_req), 64'd1);
    rst = 1'b1; imem_valid = 1'b1; imem_rdata = JUNK;
    tick();
    chk("s7_discard", 64'(inst), 64'd0);
    rst = 1'b0; imem_valid = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
